// File: rtl/dot_product_row_feeder_pkg.sv
// Shared definitions for the dot-product row feeder: FSM encodings,
// the +0.0 padding constant and the package-count helper.
package dot_product_row_feeder_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_DP   = 3'd1,
    S_FETCH    = 3'd2,
    S_LOAD     = 3'd3,
    S_PRESENT  = 3'd4,
    S_WAIT_RDY = 3'd5,
    S_WAIT_FIN = 3'd6
  } feeder_state_e;

  // IEEE-754 single +0.0, used for the padded tail elements
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // ceil(num/den) without forming num+den-1, so it cannot overflow
  function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
    return (num == 32'd0) ? 32'd0 : ((num - 32'd1) / den) + 32'd1;
  endfunction

endpackage

// File: rtl/dot_product_row_feeder_tail_mask.sv
// feeder_tail_mask: forces elements at index >= valid_cnt to +0.0.
// Element 0 sits in the MSBs of the package word.
module feeder_tail_mask
  import dot_product_row_feeder_pkg::*;
#(
  parameter int element_width = 32,
  parameter int no_of_units   = 8
) (
  input  logic [element_width*no_of_units-1:0] row_in,
  input  logic [31:0]                          valid_cnt,
  output logic [element_width*no_of_units-1:0] row_out
);

  for (genvar i = 0; i < no_of_units; i++) begin : g_el
    localparam int LSB = (no_of_units - 1 - i) * element_width;
    assign row_out[LSB +: element_width] = (32'(i) < valid_cnt) ? row_in[LSB +: element_width]
                                                                : element_width'(FP_ZERO);
  end

endmodule

// File: rtl/dot_product_row_feeder.sv
// dot_product_row_feeder: fetches A/B package words from two read-only banks,
// presents them to the dot-product engine one package at a time and collects
// the final result.
// Optional feature: define FEEDER_WATCHDOG_EN to abort jobs that stall in
// WAIT_RDY / WAIT_FIN for wdog_cycles cycles (error flag + done with result 0).
module dot_product_row_feeder
  import dot_product_row_feeder_pkg::*;
#(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int addr_width    = 10,
  parameter int wdog_cycles   = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [addr_width-1:0]                base_a,
  input  logic [addr_width-1:0]                base_b,
  input  logic [31:0]                          length,
  output logic [addr_width-1:0]                mem_addr,
  output logic                                 mem_rd,
  input  logic [element_width*no_of_units-1:0] mem_a_data,
  input  logic [element_width*no_of_units-1:0] mem_b_data,
  output logic                                 dp_reset,
  output logic [element_width*no_of_units-1:0] first_row,
  output logic [element_width*no_of_units-1:0] second_row,
  output logic                                 dp_read_now,
  output logic [31:0]                          dp_total,
  input  logic                                 dp_ready,
  input  logic                                 dp_finish,
  input  logic [element_width-1:0]             dp_result,
  output logic                                 busy,
  output logic                                 done,
  output logic [element_width-1:0]             result,
  output logic                                 error
);

  localparam int          ROW_W = element_width * no_of_units;
  localparam logic [31:0] UNITS = 32'(no_of_units);

  feeder_state_e state, state_nxt;

  logic [addr_width-1:0] base_a_q, base_b_q;
  logic [31:0]           len_q, pkts_q, pkt;
  logic [31:0]           rem, valid_cnt;
  logic                  last_pkt;
  logic [ROW_W-1:0]      a_masked, b_masked;
  logic                  go_job, go_empty, adv, take_res, abort;

  // Banks share one address; the host places B so that the same offset
  // lines up, so base_b is only recorded for the job.
  logic unused_base_b;
  assign unused_base_b = ^base_b_q;

  assign rem       = len_q % UNITS;
  assign last_pkt  = (pkt == pkts_q - 32'd1);
  assign valid_cnt = (last_pkt && rem != 32'd0) ? rem : UNITS;

  feeder_tail_mask #(.element_width(element_width), .no_of_units(no_of_units)) u_mask_a (
    .row_in(mem_a_data), .valid_cnt(valid_cnt), .row_out(a_masked)
  );
  feeder_tail_mask #(.element_width(element_width), .no_of_units(no_of_units)) u_mask_b (
    .row_in(mem_b_data), .valid_cnt(valid_cnt), .row_out(b_masked)
  );

`ifdef FEEDER_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(wdog_cycles - 1);
  logic [31:0] wdog_cnt;
  logic        error_q;
`else
  localparam int unused_wdog_cycles = wdog_cycles;
`endif

  // Next-state logic and Moore strobes decoded from the current state
  always_comb begin
    state_nxt   = state;
    go_job      = 1'b0;
    go_empty    = 1'b0;
    adv         = 1'b0;
    take_res    = 1'b0;
    abort       = 1'b0;
    mem_rd      = 1'b0;
    dp_reset    = 1'b0;
    dp_read_now = 1'b0;
    busy        = (state != S_IDLE);
    mem_addr    = '0;
    case (state)
      S_IDLE: if (start) begin
        if (length == 32'd0) go_empty = 1'b1;
        else begin
          go_job    = 1'b1;
          state_nxt = S_RST_DP;
        end
      end
      S_RST_DP: begin
        dp_reset  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_rd    = 1'b1;
        mem_addr  = base_a_q + pkt[addr_width-1:0];
        state_nxt = S_LOAD;
      end
      S_LOAD:    state_nxt = S_PRESENT;
      S_PRESENT: begin
        dp_read_now = 1'b1;
        state_nxt   = S_WAIT_RDY;
      end
      S_WAIT_RDY: if (dp_ready) begin
        adv       = 1'b1;
        state_nxt = last_pkt ? S_WAIT_FIN : S_FETCH;
      end
      S_WAIT_FIN: if (dp_finish) begin
        take_res  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
`ifdef FEEDER_WATCHDOG_EN
    // A stall of wdog_cycles in a wait state abandons the job
    if ((state == S_WAIT_RDY || state == S_WAIT_FIN) && state_nxt == state &&
        wdog_cnt == WDOG_LAST) begin
      abort     = 1'b1;
      state_nxt = S_IDLE;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Job registers, package rows and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      base_a_q   <= '0;
      base_b_q   <= '0;
      len_q      <= '0;
      pkts_q     <= '0;
      pkt        <= '0;
      dp_total   <= '0;
      first_row  <= '0;
      second_row <= '0;
      result     <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go_job || go_empty) begin
        base_a_q <= base_a;
        base_b_q <= base_b;
        len_q    <= length;
        pkts_q   <= ceil_div(length, UNITS);
        dp_total <= ceil_div(length, UNITS) * UNITS;
        pkt      <= '0;
      end
      if (go_empty || abort) begin
        done   <= 1'b1;
        result <= '0;
      end
      if (state == S_LOAD) begin
        first_row  <= a_masked;
        second_row <= b_masked;
      end
      if (adv) pkt <= pkt + 32'd1;
      if (take_res) begin
        result <= dp_result;
        done   <= 1'b1;
      end
    end
  end

`ifdef FEEDER_WATCHDOG_EN
  // Stall counter restarts on every state change; error sticks until next start
  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      error_q  <= 1'b0;
    end else begin
      wdog_cnt <= (state_nxt != state) ? 32'd0 : wdog_cnt + 32'd1;
      if (go_job || go_empty) error_q <= 1'b0;
      else if (abort)         error_q <= 1'b1;
    end
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule
